knap_candidate_sweeper: RTL and testbench
=========================================

// Module: knap_candidate_sweeper
// PURPOSE
//  Upstream driver for the combinational knapsack checker. Enumerates every item-selection vector
//  0..2^N_ITEMS-1, one per clock, on sel; samples the checker's valid result on cand_valid.
//  Records the first feasible selection and a saturating count of feasible selections.
//  Reports completion through a start/busy/done handshake to the host or sequencer.
// PARAMETERS
//  N_ITEMS   26  item count; width of sel / first_sel (checker inputs A..Z map to sel[0]..sel[25])
//  COUNT_W   16  width of hit_count (saturating)
// PORTS
//  clk        in   1        single clock; all state updates on posedge
//  rst        in   1        synchronous, active-high reset
//  start      in   1        begin a sweep; honoured in IDLE or DONE, ignored while busy
//  abort      in   1        stop a running sweep; ignored outside SWEEP
//  cand_valid in   1        checker result for the current sel, same cycle (combinational return path)
//  sel        out  N_ITEMS  registered candidate selection vector to checker
//  busy       out  1        high in SWEEP
//  done       out  1        high in DONE; held until next start or rst
//  aborted    out  1        valid with done; 1 = sweep ended by abort
//  found      out  1        at least one feasible candidate seen in current/last sweep
//  first_sel  out  N_ITEMS  lowest-index feasible selection (0 when !found)
//  hit_count  out  COUNT_W  number of feasible candidates, saturates at 2^COUNT_W-1
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE; sel=0, busy=0, done=0, aborted=0, found=0, first_sel=0, hit_count=0.
//    rst mid-sweep discards everything; no done is produced.
//  - FSM IDLE -> SWEEP on start; SWEEP -> DONE on last candidate | abort | early stop; DONE -> SWEEP on start.
//  - Start cycle (IDLE/DONE, start=1): next cycle state=SWEEP, sel=0. found, first_sel, hit_count and aborted clear.
//  - SWEEP cycle with abort=0: cand_valid is evaluated against the current sel.
//    If cand_valid=1: hit_count += 1 (holds at max); if !found then found<=1, first_sel<=sel.
//    If sel==all-ones: next state DONE, sel holds. Otherwise sel<=sel+1 (no wrap).
//  - SWEEP cycle with abort=1: candidate NOT evaluated; next state DONE, aborted<=1, sel holds.
//    Abort has priority over cand_valid and over the last-candidate condition.
//  - Latency: a full sweep is exactly 2^N_ITEMS SWEEP cycles; done rises on the cycle after the all-ones candidate.
//  - start during SWEEP is ignored. start and abort together in SWEEP: abort wins.
//  - Outputs found/first_sel/hit_count are live during SWEEP and frozen in DONE.
//  - Arithmetic: sel increment is N_ITEMS bits and its end is detected by compare, never by overflow.
//    hit_count increment is COUNT_W bits with a saturation guard.
// CONFIGURATION
//  KNAP_STOP_FIRST_EN defined:
//    - In SWEEP, cand_valid=1 (and abort=0) records the hit and moves next state to DONE. sel holds there.
//    - hit_count is therefore 0 or 1 at done.
//  KNAP_STOP_FIRST_EN undefined:
//    - The sweep always covers the full range unless aborted.
//    - hit_count is the total feasible count (saturating).
// STRUCTURE
//  - Package knap_pkg: localparam N_ITEMS_DEF=26 and COUNT_W_DEF=16.
//  - knap_pkg also holds typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} knap_sweep_st_t.
//  - Sub-module knap_sat_counter (parameter W; inputs clk, rst, clr, inc; output cnt) implements hit_count.
//  - Checker is instantiated outside this block; sel/cand_valid form the only interface.
// TESTING  (N_ITEMS=4, COUNT_W=2, mock checker: cand_valid = sel==4'h5 | sel==4'h9 | sel==4'hC | sel==4'hE)
//  1. rst for 2 cycles, then idle: sel=0, busy=0, done=0, found=0, hit_count=0, first_sel=0.
//  2. start pulse, stop-first off -> busy for 16 cycles, sel 0..15.
//     done=1, aborted=0, found=1, first_sel=4'h5, hit_count=3 (saturated from 4).
//  3. KNAP_STOP_FIRST_EN defined, start -> busy 6 cycles (sel 0..5).
//     done=1, first_sel=4'h5, hit_count=1, sel holds 4'h5.
//  4. start, abort asserted when sel==4'h5 -> done next cycle, aborted=1, found=0, hit_count=0.
//  5. checker forced 0, start -> done after 16 cycles, found=0, first_sel=0.
//     Second start in DONE restarts with cleared results; start pulsed mid-sweep has no effect.
//  6. rst asserted when sel==4'h7 -> next cycle IDLE, all outputs at reset values, done never rises.

Source files
------------

// File: rtl/knap_candidate_sweeper_pkg.sv
// Shared types and defaults for the knapsack candidate sweeper.
// KNAP_STOP_FIRST_EN selects stop-on-first-feasible sweeps.
package knap_pkg;

    localparam int N_ITEMS_DEF = 26;
    localparam int COUNT_W_DEF = 16;

`ifdef KNAP_STOP_FIRST_EN
    localparam bit STOP_FIRST_EN = 1'b1;
`else
    localparam bit STOP_FIRST_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DONE
    } knap_sweep_st_t;

endpackage

// File: rtl/knap_candidate_sweeper_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Latency: count visible one cycle after inc. No backpressure.
module knap_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/knap_candidate_sweeper.sv
// Enumerates selection vectors for the combinational knapsack checker, one per clock.
// Latency: full sweep is 2^N_ITEMS SWEEP cycles, done the cycle after; no backpressure (abort only).
// KNAP_STOP_FIRST_EN ends the sweep on the first feasible candidate.
module knap_candidate_sweeper
    import knap_pkg::*;
#(
    parameter int N_ITEMS = N_ITEMS_DEF,
    parameter int COUNT_W = COUNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               cand_valid,
    output logic [N_ITEMS-1:0] sel,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               found,
    output logic [N_ITEMS-1:0] first_sel,
    output logic [COUNT_W-1:0] hit_count
);

    localparam logic [N_ITEMS-1:0] SEL_LAST = {N_ITEMS{1'b1}};
    localparam logic [N_ITEMS-1:0] SEL_ONE  = {{(N_ITEMS-1){1'b0}}, 1'b1};

    knap_sweep_st_t     state, state_nxt;
    logic [N_ITEMS-1:0] sel_q, sel_nxt;
    logic [N_ITEMS-1:0] first_q, first_nxt;
    logic               found_q, found_nxt;
    logic               aborted_q, aborted_nxt;
    logic               cnt_clr, cnt_inc;
    logic               hit_stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sel_q     <= '0;
            first_q   <= '0;
            found_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            sel_q     <= sel_nxt;
            first_q   <= first_nxt;
            found_q   <= found_nxt;
            aborted_q <= aborted_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel_q;
        first_nxt   = first_q;
        found_nxt   = found_q;
        aborted_nxt = aborted_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        hit_stop    = STOP_FIRST_EN && cand_valid;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt   = ST_SWEEP;
                    sel_nxt     = '0;
                    first_nxt   = '0;
                    found_nxt   = 1'b0;
                    aborted_nxt = 1'b0;
                    cnt_clr     = 1'b1;
                end
            end
            ST_SWEEP: begin
                // Abort discards the current candidate entirely.
                if (abort) begin
                    state_nxt   = ST_DONE;
                    aborted_nxt = 1'b1;
                end else begin
                    if (cand_valid) begin
                        cnt_inc = 1'b1;
                        if (!found_q) begin
                            found_nxt = 1'b1;
                            first_nxt = sel_q;
                        end
                    end
                    if (hit_stop || (sel_q == SEL_LAST)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        sel_nxt = sel_q + SEL_ONE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    knap_sat_counter #(.W(COUNT_W)) u_hit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .cnt (hit_count)
    );

    assign sel       = sel_q;
    assign first_sel = first_q;
    assign found     = found_q;
    assign aborted   = aborted_q;
    assign busy      = (state == ST_SWEEP);
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_knap_candidate_sweeper.sv
// Directed bench for knap_candidate_sweeper (N_ITEMS=4, COUNT_W=2) with a mock checker.
module tb_knap_candidate_sweeper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       force0 = 1'b0;
    logic       cand_valid;
    logic [3:0] sel;
    logic       busy, done, aborted, found;
    logic [3:0] first_sel;
    logic [1:0] hit_count;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_sel_q[$];

`ifdef KNAP_STOP_FIRST_EN
    localparam bit STOP_FIRST = 1'b1;
`else
    localparam bit STOP_FIRST = 1'b0;
`endif

    always #5 clk = ~clk;

    assign cand_valid = !force0 && (sel == 4'h5 || sel == 4'h9 || sel == 4'hC || sel == 4'hE);

    knap_candidate_sweeper #(.N_ITEMS(4), .COUNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .cand_valid (cand_valid),
        .sel        (sel),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .found      (found),
        .first_sel  (first_sel),
        .hit_count  (hit_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit mock_valid(input int s, input bit f0);
        return !f0 && (s == 5 || s == 9 || s == 12 || s == 14);
    endfunction

    // Model the sweep, queue the expected sel per busy cycle, then compare DUT as it runs.
    task automatic run_sweep(input string tag, input int abort_at, input bit f0, input int mid_start_at);
        int  e_hits = 0;
        bit  e_found = 1'b0;
        int  e_first = 0;
        bit  e_abort = 1'b0;
        int  e_last = 0;
        int  e_len;
        int  cycles = 0;
        exp_sel_q.delete();
        for (int s = 0; s < 16; s++) begin
            exp_sel_q.push_back(s);
            e_last = s;
            if (s == abort_at) begin
                e_abort = 1'b1;
                break;
            end
            if (mock_valid(s, f0)) begin
                if (e_hits < 3) e_hits++;
                if (!e_found) begin
                    e_found = 1'b1;
                    e_first = s;
                end
                if (STOP_FIRST) break;
            end
        end
        e_len = exp_sel_q.size();

        force0 = f0;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk({tag, "_start_busy"}, 32'(busy), 1);
        chk({tag, "_start_clr"}, {28'b0, done, aborted, found, 1'b0} | 32'(hit_count), 0);

        while (busy && cycles < 40) begin
            cycles++;
            if (exp_sel_q.size() == 0) begin
                chk({tag, "_overrun_sel"}, 32'(sel), 32'hFFFF);
            end else begin
                chk({tag, "_sel"}, 32'(sel), 32'(exp_sel_q.pop_front()));
            end
            abort = (int'(sel) == abort_at);
            start = (int'(sel) == mid_start_at);
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
        end

        chk({tag, "_cycles"}, 32'(cycles), 32'(e_len));
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_aborted"}, 32'(aborted), 32'(e_abort));
        chk({tag, "_found"}, 32'(found), 32'(e_found));
        chk({tag, "_first_sel"}, 32'(first_sel), 32'(e_first));
        chk({tag, "_hit_count"}, 32'(hit_count), 32'(e_hits));
        chk({tag, "_sel_hold"}, 32'(sel), 32'(e_last));
        force0 = 1'b0;
    endtask

    initial begin
        int done_seen;
        int guard;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_found", 32'(found), 0);
        chk("rst_hit", 32'(hit_count), 0);
        chk("rst_first", 32'(first_sel), 0);

        // Abort ignored while idle
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_done", 32'(done), 0);

        // Full sweep (or stop-first sweep when the macro is defined)
        run_sweep("full", -1, 1'b0, -1);

        // Held in DONE
        repeat (3) @(negedge clk);
        chk("done_hold", 32'(done), 1);
        chk("done_hold_hit", 32'(hit_count), STOP_FIRST ? 1 : 3);

        // Abort at sel 5
        run_sweep("abort", 5, 1'b0, -1);

        // Checker forced low, then restart from DONE with a mid-sweep start pulse
        run_sweep("zero", -1, 1'b1, -1);
        run_sweep("restart", -1, 1'b0, 3);

        // Reset mid-sweep at sel 7
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        guard = 0;
        @(negedge clk);
        while (sel != 4'h7 && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        chk("rst_mid_reach7", 32'(sel), 7);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_state", {28'b0, busy, done, aborted, found}, 0);
        chk("rst_mid_sel", 32'(sel), 0);
        chk("rst_mid_first", 32'(first_sel), 0);
        chk("rst_mid_hit", 32'(hit_count), 0);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        chk("rst_mid_no_done", 32'(done_seen), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
